// File: rtl/sid_regs.sv
// SID register file: bus decode into per-voice and filter/volume fields,
// read-only source readback, and a decaying bus data latch that mimics the
// floating data bus of the original chip.
//
// Bus handshake: an access is accepted on a rising clk edge where clk_en=1,
// bus_cs=1 and armed=1. Acceptance clears armed, and armed is set again on
// any edge with bus_cs=0, so holding bus_cs high yields exactly one access.
// There is no ready; the host is never stalled. A read answers with
// bus_rdata updated at the accepting edge and bus_rvalid high for exactly
// the following clk cycle.
module sid_regs #(
  parameter int DECAY_CYCLES = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              bus_cs,
  input  logic              bus_rw,
  input  logic [4:0]        bus_addr,
  input  logic [7:0]        bus_wdata,
  output logic [7:0]        bus_rdata,
  output logic              bus_rvalid,
  input  logic [7:0]        potx,
  input  logic [7:0]        poty,
  input  logic [7:0]        osc3,
  input  logic [7:0]        env3,
  output logic [2:0][15:0]  r_freq,
  output logic [2:0][11:0]  r_pw,
  output logic [2:0][7:0]   r_ctrl,
  output logic [2:0][7:0]   r_ad,
  output logic [2:0][7:0]   r_sr,
  output logic [10:0]       r_fc,
  output logic [3:0]        r_res,
  output logic [3:0]        r_filt,
  output logic [3:0]        r_mode,
  output logic [3:0]        r_vol
);

  localparam int CW = $clog2(DECAY_CYCLES + 1);
  localparam logic [CW-1:0] DECAY_MAX = CW'(DECAY_CYCLES);

  logic          armed;
  logic [7:0]    bus_latch;
  logic [CW-1:0] decay_cnt;

  logic          accept;
  logic          wr_acc;
  logic          rd_acc;
  logic          src_hit;
  logic [7:0]    src_val;
  logic [7:0]    rd_value;
  logic          decay_hit;

  // Access acceptance, source mux and decay-expiry detection.
  always_comb begin
    accept    = clk_en && bus_cs && armed;
    wr_acc    = accept && !bus_rw;
    rd_acc    = accept && bus_rw;
    src_hit   = 1'b1;
    src_val   = 8'h00;
    case (bus_addr)
      5'h19:   src_val = potx;
      5'h1A:   src_val = poty;
      5'h1B:   src_val = osc3;
      5'h1C:   src_val = env3;
      default: src_hit = 1'b0;
    endcase
    rd_value  = src_hit ? src_val : bus_latch;
    // Expiry is the edge on which the counter steps onto DECAY_CYCLES.
    decay_hit = clk_en && !accept && (decay_cnt == DECAY_MAX - CW'(1));
  end

  // Re-arm whenever chip select is low; disarm on an accepted access.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
    end else if (!bus_cs) begin
      armed <= 1'b1;
    end else if (accept) begin
      armed <= 1'b0;
    end
  end

  // Write decode into the voice and filter/volume fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq <= '0;
      r_pw   <= '0;
      r_ctrl <= '0;
      r_ad   <= '0;
      r_sr   <= '0;
      r_fc   <= '0;
      r_res  <= '0;
      r_filt <= '0;
      r_mode <= '0;
      r_vol  <= '0;
    end else if (wr_acc) begin
      for (int v = 0; v < 3; v++) begin
        if (bus_addr == 5'(7 * v + 0)) r_freq[v][7:0]  <= bus_wdata;
        if (bus_addr == 5'(7 * v + 1)) r_freq[v][15:8] <= bus_wdata;
        if (bus_addr == 5'(7 * v + 2)) r_pw[v][7:0]    <= bus_wdata;
        if (bus_addr == 5'(7 * v + 3)) r_pw[v][11:8]   <= bus_wdata[3:0];
        if (bus_addr == 5'(7 * v + 4)) r_ctrl[v]       <= bus_wdata;
        if (bus_addr == 5'(7 * v + 5)) r_ad[v]         <= bus_wdata;
        if (bus_addr == 5'(7 * v + 6)) r_sr[v]         <= bus_wdata;
      end
      case (bus_addr)
        5'h15: r_fc[2:0]  <= bus_wdata[2:0];
        5'h16: r_fc[10:3] <= bus_wdata;
        5'h17: begin
          r_res  <= bus_wdata[7:4];
          r_filt <= bus_wdata[3:0];
        end
        5'h18: begin
          r_mode <= bus_wdata[7:4];
          r_vol  <= bus_wdata[3:0];
        end
        default: ;
      endcase
    end
  end

  // Bus latch: loads on every access, clears when the decay counter expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_latch <= 8'h00;
    end else if (accept) begin
      bus_latch <= bus_rw ? rd_value : bus_wdata;
    end else if (decay_hit) begin
      bus_latch <= 8'h00;
    end
  end

  // Decay counter: restarts on access, counts clk_en ticks, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      decay_cnt <= '0;
    end else if (accept) begin
      decay_cnt <= '0;
    end else if (clk_en && decay_cnt != DECAY_MAX) begin
      decay_cnt <= decay_cnt + CW'(1);
    end
  end

  // Read data register and its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_rdata  <= 8'h00;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= rd_acc;
      if (rd_acc) begin
        bus_rdata <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_sid_regs.sv
// Bench for sid_regs: directed scenarios with hand-computed values, then
// randomized bus traffic checked every cycle against a byte-image model.
module tb_sid_regs;

  localparam int DECAY = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_en = 1'b0;
  logic              bus_cs = 1'b0;
  logic              bus_rw = 1'b0;
  logic [4:0]        bus_addr = '0;
  logic [7:0]        bus_wdata = '0;
  logic [7:0]        potx = '0, poty = '0, osc3 = '0, env3 = '0;
  logic [7:0]        bus_rdata;
  logic              bus_rvalid;
  logic [2:0][15:0]  r_freq;
  logic [2:0][11:0]  r_pw;
  logic [2:0][7:0]   r_ctrl, r_ad, r_sr;
  logic [10:0]       r_fc;
  logic [3:0]        r_res, r_filt, r_mode, r_vol;

  sid_regs #(.DECAY_CYCLES(DECAY)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus_cs(bus_cs),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .potx(potx), .poty(poty), .osc3(osc3), .env3(env3),
    .r_freq(r_freq), .r_pw(r_pw), .r_ctrl(r_ctrl), .r_ad(r_ad), .r_sr(r_sr),
    .r_fc(r_fc), .r_res(r_res), .r_filt(r_filt), .r_mode(r_mode), .r_vol(r_vol)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  // Image of the written bytes at 0x00..0x18; output fields are sliced from it.
  logic [7:0] m_reg [0:24];
  logic [7:0] m_latch;
  logic [7:0] m_rdata;
  bit         m_rvalid;
  bit         m_armed;
  int         m_idle;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    bit         acc;
    logic [7:0] v;
    if (reset) begin
      for (int i = 0; i < 25; i++) m_reg[i] = 8'h00;
      m_latch  = 8'h00;
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_armed  = 1'b1;
      m_idle   = 0;
    end else begin
      acc      = clk_en && bus_cs && m_armed;
      m_rvalid = 1'b0;
      if (!bus_cs) m_armed = 1'b1;
      else if (acc) m_armed = 1'b0;
      if (acc) begin
        m_idle = 0;
        if (!bus_rw) begin
          if (int'(bus_addr) < 25) m_reg[bus_addr] = bus_wdata;
          m_latch = bus_wdata;
        end else begin
          case (bus_addr)
            5'h19:   begin v = potx; m_latch = v; end
            5'h1A:   begin v = poty; m_latch = v; end
            5'h1B:   begin v = osc3; m_latch = v; end
            5'h1C:   begin v = env3; m_latch = v; end
            default: v = m_latch;
          endcase
          m_rdata  = v;
          m_rvalid = 1'b1;
          exp_q.push_back(v);
        end
      end else if (clk_en && m_idle < DECAY) begin
        m_idle++;
        if (m_idle == DECAY) m_latch = 8'h00;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (chk_on) begin
      chk("rvalid", 64'(bus_rvalid), 64'(m_rvalid));
      chk("rdata", 64'(bus_rdata), 64'(m_rdata));
      if (bus_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 64'(bus_rdata), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("rd_queue", 64'(bus_rdata), 64'(e));
        end
      end
      for (int v = 0; v < 3; v++) begin
        chk("freq", 64'(r_freq[v]), 64'({m_reg[7*v+1], m_reg[7*v]}));
        chk("pw", 64'(r_pw[v]), 64'({m_reg[7*v+3][3:0], m_reg[7*v+2]}));
        chk("ctrl_ad_sr", 64'({r_ctrl[v], r_ad[v], r_sr[v]}),
            64'({m_reg[7*v+4], m_reg[7*v+5], m_reg[7*v+6]}));
      end
      chk("filter", 64'({r_fc, r_res, r_filt, r_mode, r_vol}),
          64'({m_reg[22], m_reg[21][2:0], m_reg[23], m_reg[24]}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus_cs = 1'b1; bus_rw = 1'b0; bus_addr = a; bus_wdata = d; clk_en = 1'b1;
    tick();
    bus_cs = 1'b0; clk_en = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [4:0] a);
    bus_cs = 1'b1; bus_rw = 1'b1; bus_addr = a; clk_en = 1'b1;
    tick();
    bus_cs = 1'b0; clk_en = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    bus_cs = 1'b0; clk_en = 1'b1;
    repeat (n) tick();
    clk_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset_rdata", 64'(bus_rdata), 64'h00);
    chk("reset_rvalid", 64'(bus_rvalid), 64'h0);
    chk("reset_freq", 64'(r_freq), 64'h0);
    reset = 1'b0;
    tick();

    // Frequency byte assembly.
    wr(5'h01, 8'hAB);
    wr(5'h00, 8'hCD);
    chk("lit_freq0", 64'(r_freq[0]), 64'hABCD);
    chk("lit_freq1", 64'(r_freq[1]), 64'h0);
    chk("lit_freq2", 64'(r_freq[2]), 64'h0);

    // Pulse width high nibble, then readback of a write-only register.
    wr(5'h0A, 8'hF7);
    chk("lit_pw1", 64'(r_pw[1]), 64'h700);
    bus_cs = 1'b1; bus_rw = 1'b1; bus_addr = 5'h0A; clk_en = 1'b1;
    tick();
    chk("lit_rd0a_data", 64'(bus_rdata), 64'hF7);
    chk("lit_rd0a_valid", 64'(bus_rvalid), 64'h1);
    bus_cs = 1'b0; clk_en = 1'b0;
    tick();
    chk("lit_rd0a_valid_drop", 64'(bus_rvalid), 64'h0);
    chk("lit_rd0a_hold", 64'(bus_rdata), 64'hF7);

    // Source read loads the latch.
    osc3 = 8'h5A;
    rd(5'h1B);
    chk("lit_osc3", 64'(bus_rdata), 64'h5A);
    rd(5'h00);
    chk("lit_latch", 64'(bus_rdata), 64'h5A);
    chk("lit_model_latch", 64'(m_rdata), 64'h5A);

    // Decay boundary: 15 idle ticks keep the latch, 16 clear it.
    wr(5'h04, 8'h41);
    chk("lit_ctrl0", 64'(r_ctrl[0]), 64'h41);
    idle(DECAY - 1);
    rd(5'h1D);
    chk("lit_decay_keep", 64'(bus_rdata), 64'h41);
    idle(DECAY);
    rd(5'h1D);
    chk("lit_decay_clear", 64'(bus_rdata), 64'h00);
    chk("lit_model_decay", 64'(m_rdata), 64'h00);

    // Held chip select gives one access; re-assert gives another.
    bus_cs = 1'b1; bus_rw = 1'b0; bus_addr = 5'h12; clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_wdata = 8'(8'h11 * (i + 1));
      tick();
    end
    chk("lit_hold_once", 64'(r_ctrl[2]), 64'h11);
    bus_cs = 1'b0;
    tick();
    bus_cs = 1'b1; bus_wdata = 8'h99;
    tick();
    chk("lit_hold_rearm", 64'(r_ctrl[2]), 64'h99);
    bus_cs = 1'b0; clk_en = 1'b0;
    tick();

    // Reset clears fields and read data.
    rd(5'h1B);
    wr(5'h18, 8'h1F);
    chk("lit_mode", 64'(r_mode), 64'h1);
    chk("lit_vol", 64'(r_vol), 64'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("lit_rst_mode", 64'(r_mode), 64'h0);
    chk("lit_rst_vol", 64'(r_vol), 64'h0);
    chk("lit_rst_rdata", 64'(bus_rdata), 64'h00);
    chk("lit_rst_rvalid", 64'(bus_rvalid), 64'h0);

    // Reset overrides a held access, which is accepted again afterwards.
    bus_cs = 1'b1; bus_rw = 1'b1; bus_addr = 5'h1B; clk_en = 1'b1; reset = 1'b1;
    tick();
    chk("lit_rst_override", 64'(bus_rvalid), 64'h0);
    reset = 1'b0;
    tick();
    chk("lit_post_rst_valid", 64'(bus_rvalid), 64'h1);
    chk("lit_post_rst_data", 64'(bus_rdata), 64'h5A);
    bus_cs = 1'b0; clk_en = 1'b0;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clk_en    = ($urandom_range(0, 9) < 7);
      bus_cs    = ($urandom_range(0, 1) == 1);
      bus_rw    = ($urandom_range(0, 1) == 1);
      bus_addr  = 5'($urandom_range(0, 31));
      bus_wdata = 8'($urandom);
      potx      = 8'($urandom);
      poty      = 8'($urandom);
      osc3      = 8'($urandom);
      env3      = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus_cs = 1'b0;
        clk_en = 1'b1;
        repeat ($urandom_range(1, DECAY + 2)) tick();
      end
      tick();
    end
    reset = 1'b0; bus_cs = 1'b0; clk_en = 1'b0;
    repeat (3) tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sid_regs.md
SID_REGS -- requirements
Module: sid_regs

Interface
REQ-001 SHALL have parameter DECAY_CYCLES, default 8192, meaning the number of clk_en ticks without a bus access before the bus data latch clears to 0.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port clk_en  in  1  SID bus-cycle enable; bus sampling and decay counting occur only when high.
REQ-005 SHALL have port bus_cs  in  1  chip select, active-high.
REQ-006 SHALL have port bus_rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port bus_addr  in  5  register address 0x00-0x1F.
REQ-008 SHALL have port bus_wdata  in  8  write data.
REQ-009 SHALL have port bus_rdata  out  8  registered read data.
REQ-010 SHALL have port bus_rvalid  out  1  one-clk pulse when bus_rdata is updated by a read.
REQ-011 SHALL have ports potx, poty, osc3, env3  in  8 each  read-only sources.
REQ-012 SHALL have ports r_freq  out  3x16, r_pw  out  3x12, r_ctrl  out  3x8, r_ad  out  3x8, r_sr  out  3x8, per-voice fields.
REQ-013 SHALL have ports r_fc  out  11, r_res  out  4, r_filt  out  4, r_mode  out  4, r_vol  out  4, filter and volume fields.

Function
REQ-014 Access SHALL be accepted at a clk edge with clk_en=1, bus_cs=1 and armed=1; acceptance clears armed.
REQ-015 armed SHALL set at any clk edge where bus_cs=0; holding cs high yields exactly one access.
REQ-016 Voice n (0..2), base 7n: +0 freq[7:0], +1 freq[15:8], +2 pw[7:0], +3 pw[11:8] from wdata[3:0] (wdata[7:4] discarded), +4 ctrl, +5 ad, +6 sr.
REQ-017 0x15 SHALL write fc[2:0] from wdata[2:0]; 0x16 SHALL write fc[10:3].
REQ-018 0x17 SHALL write res=wdata[7:4], filt=wdata[3:0]; 0x18 SHALL write mode=wdata[7:4], vol=wdata[3:0].
REQ-019 Writes to 0x19-0x1F SHALL not change any output register.
REQ-020 An accepted write SHALL update its field at the accepting edge, visible on outputs the following cycle; the bus latch SHALL load wdata.
REQ-021 Accepted reads of 0x19/0x1A/0x1B/0x1C SHALL return potx/poty/osc3/env3 as sampled at the accepting edge, and SHALL load the bus latch with that value.
REQ-022 Accepted reads of any other address SHALL return the current bus latch value, leaving the latch unchanged.
REQ-023 On an accepted read, bus_rdata SHALL update at the accepting edge and bus_rvalid SHALL be 1 for exactly the next clk cycle; bus_rdata holds until the next read.
REQ-024 Writes SHALL never change bus_rdata or assert bus_rvalid.
REQ-025 Decay counter (width ceil(log2(DECAY_CYCLES+1))) SHALL reload to 0 on every accepted access and increment on every other clk_en=1 edge, saturating at DECAY_CYCLES.
REQ-026 When the counter reaches DECAY_CYCLES, the bus latch SHALL clear to 0x00 at that edge; the counter then stays saturated until the next access.
REQ-027 If an access and decay expiry coincide, the access SHALL win: the latch loads the access value and the counter reloads to 0.
REQ-028 With clk_en=0, all state SHALL hold except armed (REQ-015) and the falling edge of bus_rvalid.

Reset
REQ-029 reset=1 at a clk edge SHALL clear all r_* outputs, bus_rdata, bus_rvalid, bus latch and decay counter to 0, and set armed=1, regardless of clk_en or bus_cs.
REQ-030 reset SHALL override a simultaneous access; an access in progress (cs held high) SHALL be accepted again after reset deasserts if clk_en=1.

Verification
REQ-031 Write 0x01=0xAB, then 0x00=0xCD -> r_freq[0]=0xABCD; r_freq[1] and r_freq[2] remain 0.
REQ-032 Write 0x0A=0xF7 -> r_pw[1]=0x700; then read 0x0A -> bus_rdata=0xF7, single-cycle bus_rvalid.
REQ-033 With osc3=0x5A, read 0x1B -> bus_rdata=0x5A; then read 0x00 -> bus_rdata=0x5A (latch).
REQ-034 DECAY_CYCLES=16: write 0x04=0x41, idle 15 clk_en ticks, read 0x1D -> 0x41; idle 16 ticks, read 0x1D -> 0x00.
REQ-035 Hold bus_cs=1, bus_rw=0 for 5 clk_en ticks while changing wdata -> only the first value is written; deassert and reassert cs -> a second write is accepted.
REQ-036 Assert reset for one edge after writing 0x18=0x1F -> r_mode=0, r_vol=0, bus_rdata=0, bus_rvalid=0.
